multi_button_debouncer: RTL and testbench
=========================================

// Module: multi_button_debouncer
// PURPOSE
//  Parametrised N-channel debouncer for elevator push-buttons (floor calls, cabin panel, door open/close).
//  Each channel filters its raw input independently and outputs a stable level plus 1-cycle press/release pulses.
//  Sits between the board pins and the elevator control FSM. It replaces single-channel, fixed-count debouncing.
// PARAMETERS
//  N_CH       8     number of independent button channels (>=1)
//  DB_CYCLES  1000  consecutive cycles a new level must persist before it is accepted (>=2)
//  CNT_W      10    counter width; must satisfy 2**CNT_W > DB_CYCLES (checked by elaboration assertion)
//  RST_VAL    1'b0  value of every db_level bit during and after reset (idle level of the buttons)
// PORTS
//  clk        in   1     single system clock, all logic on rising edge
//  rst        in   1     synchronous reset, active-high
//  btn_raw    in   N_CH  raw button inputs, asynchronous to clk
//  db_level   out  N_CH  debounced stable level per channel
//  db_rise    out  N_CH  1-cycle pulse when db_level goes 0->1 (press)
//  db_fall    out  N_CH  1-cycle pulse when db_level goes 1->0 (release)
//  any_change out  1     OR of all db_rise|db_fall bits, registered together with them
// BEHAVIOUR
//  - Reset (rst=1 at a clk edge): db_level<=all RST_VAL, counters<=0, db_rise/db_fall/any_change<=0.
//    Reset takes priority over everything and aborts any count in progress.
//  - Per channel, s = sampled input (btn_raw, or its synchronised copy when the sync option is enabled):
//    s==db_level: count<=0, so a glitch shorter than DB_CYCLES is fully rejected and the count restarts from zero.
//    s!=db_level and count!=DB_CYCLES-1: count<=count+1.
//    s!=db_level and count==DB_CYCLES-1: db_level<=s, count<=0, and rise or fall pulses at the same edge.
//  - Latency: s differs from db_level for DB_CYCLES consecutive cycles (k..k+DB_CYCLES-1).
//    db_level and the pulse update at the edge ending cycle k+DB_CYCLES-1.
//  - Pulses are exactly 1 cycle wide and registered. The earliest next pulse on the same channel comes DB_CYCLES cycles later.
//  - The counter never exceeds DB_CYCLES-1 and never wraps. Channels are fully independent.
//    Simultaneous transitions on several channels each produce their own pulse in the same cycle.
//  - Input toggling every cycle indefinitely: db_level holds and no pulses are produced.
// CONFIGURATION
//  DEBOUNCER_SYNC_EN defined: a 2-FF synchroniser per channel runs before the filter.
//    Synchroniser flops reset to RST_VAL. Total latency becomes DB_CYCLES+2 cycles from the btn_raw change.
//  DEBOUNCER_SYNC_EN undefined: btn_raw feeds the filter directly (for pre-synchronised inputs).
//    Latency is DB_CYCLES cycles.
// STRUCTURE
//  Package debounce_pkg holds DB_CYCLES_DEFAULT (1000) and the clog2-based width helper used for CNT_W checks.
//  Sub-module debounce_channel (one counter, stable flop, edge pulse logic) is instantiated N_CH times via generate.
//  The top level holds the optional synchroniser, channel generate loop and any_change OR-reduce/register.
// TESTING (bench uses N_CH=4, DB_CYCLES=4, RST_VAL=0, sync disabled unless noted)
//  1 Reset: hold rst=1 for 3 cycles with btn_raw=4'hF -> db_level=0, all pulses 0. After release, db_level=4'hF 4 cycles later.
//  2 Clean press: ch0 rises and holds -> db_level[0]=1 and db_rise[0]=1 for exactly 1 cycle, at the 4th edge after the change. any_change=1 in that cycle.
//  3 Glitch: ch1 high for 3 cycles, low 1 cycle, high 3 cycles -> no db_rise[1], db_level[1] stays 0.
//  4 Release and simultaneity: ch2 and ch3 pressed in the same cycle -> both db_rise pulse in the same cycle.
//    Later ch2 released -> db_fall[2] only.
//  5 Reset mid-count: ch0 differs for 2 cycles, then rst=1 for 1 cycle -> count cleared. The new level needs a full 4 cycles after reset.
//  6 DEBOUNCER_SYNC_EN defined: repeat scenario 2 -> pulse appears 6 edges after the btn_raw change.

Source files
------------

// File: rtl/debounce_pkg.sv
// Shared constants and width helper for the push-button debouncer.
package debounce_pkg;

    localparam int unsigned DB_CYCLES_DEFAULT = 1000;

    // Smallest counter width w with 2**w > cycles.
    function automatic int unsigned min_cnt_w(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-channel debounce filter: persistence counter, stable level flop, registered edge pulses.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W     = 10,
    parameter logic        RST_VAL   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sample,
    output logic o_level,
    output logic o_rise,
    output logic o_fall,
    output logic o_event_nxt
);

    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(DB_CYCLES - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_level;
    logic             r_rise;
    logic             r_fall;
    logic             w_differ;
    logic             w_accept;

    assign w_differ = (i_sample != r_level);
    assign w_accept = w_differ && (r_count == LP_LAST);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
            r_level <= RST_VAL;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
        end else begin
            r_rise <= w_accept &  i_sample;
            r_fall <= w_accept & ~i_sample;
            if (!w_differ) begin
                r_count <= '0;
            end else if (w_accept) begin
                r_level <= i_sample;
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign o_level     = r_level;
    assign o_rise      = r_rise;
    assign o_fall      = r_fall;
    // Lets the top register any_change in the same cycle as the pulses.
    assign o_event_nxt = w_accept;

endmodule

// File: rtl/multi_button_debouncer.sv
// N-channel push-button debouncer with level and press/release pulses.
// Define DEBOUNCER_SYNC_EN to insert a 2-FF synchroniser per channel ahead of the filter.
module multi_button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int unsigned CNT_W     = 10,
    parameter logic        RST_VAL   = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_raw,
    output logic [N_CH-1:0] db_level,
    output logic [N_CH-1:0] db_rise,
    output logic [N_CH-1:0] db_fall,
    output logic            any_change
);

    if (CNT_W < min_cnt_w(DB_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too small: 2**CNT_W must exceed DB_CYCLES");
    end
    if (DB_CYCLES < 2) begin : g_bad_db_cycles
        $error("DB_CYCLES must be at least 2");
    end
    if (N_CH < 1) begin : g_bad_n_ch
        $error("N_CH must be at least 1");
    end

    logic [N_CH-1:0] w_sample;
    logic [N_CH-1:0] w_event_nxt;
    logic            r_any_change;

`ifdef DEBOUNCER_SYNC_EN
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= {N_CH{RST_VAL}};
            r_sync2 <= {N_CH{RST_VAL}};
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_sample = r_sync2;
`else
    assign w_sample = btn_raw;
`endif

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES (DB_CYCLES),
            .CNT_W     (CNT_W),
            .RST_VAL   (RST_VAL)
        ) u_channel (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_sample    (w_sample[g]),
            .o_level     (db_level[g]),
            .o_rise      (db_rise[g]),
            .o_fall      (db_fall[g]),
            .o_event_nxt (w_event_nxt[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_change <= 1'b0;
        end else begin
            r_any_change <= |w_event_nxt;
        end
    end

    assign any_change = r_any_change;

endmodule

// File: tb/tb_multi_button_debouncer.sv
// Directed self-checking bench for multi_button_debouncer (N_CH=4, DB_CYCLES=4).
module tb_multi_button_debouncer;

    localparam int unsigned N_CH      = 4;
    localparam int unsigned DB_CYCLES = 4;
`ifdef DEBOUNCER_SYNC_EN
    localparam int unsigned LAT = DB_CYCLES + 2;
`else
    localparam int unsigned LAT = DB_CYCLES;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] btn_raw;
    logic [N_CH-1:0] db_level;
    logic [N_CH-1:0] db_rise;
    logic [N_CH-1:0] db_fall;
    logic            any_change;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    multi_button_debouncer #(
        .N_CH      (N_CH),
        .DB_CYCLES (DB_CYCLES),
        .CNT_W     (3),
        .RST_VAL   (1'b0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_raw    (btn_raw),
        .db_level   (db_level),
        .db_rise    (db_rise),
        .db_fall    (db_fall),
        .any_change (any_change)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Checks all outputs in one go.
    task automatic check_all(input string tag, input logic [3:0] lvl, input logic [3:0] rise,
                             input logic [3:0] fall);
        check({tag, "_level"}, 32'(db_level), 32'(lvl));
        check({tag, "_rise"},  32'(db_rise),  32'(rise));
        check({tag, "_fall"},  32'(db_fall),  32'(fall));
        check({tag, "_any"},   32'(any_change), 32'((|rise) | (|fall)));
    endtask

    logic [3:0] seen_rise;

    initial begin
        // 1: reset with all buttons held
        rst     = 1'b1;
        btn_raw = 4'hF;
        tick(3);
        check_all("rst_hold", 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        tick(LAT - 1);
        check_all("rst_pre", 4'h0, 4'h0, 4'h0);
        tick();
        check_all("rst_accept", 4'hF, 4'hF, 4'h0);
        tick();
        check_all("rst_after", 4'hF, 4'h0, 4'h0);
        btn_raw = 4'h0;
        tick(LAT);
        check_all("rel_all", 4'h0, 4'h0, 4'hF);
        tick();
        check_all("rel_all_after", 4'h0, 4'h0, 4'h0);

        // 2: clean press on ch0
        btn_raw = 4'h1;
        tick(LAT - 1);
        check_all("press_pre", 4'h0, 4'h0, 4'h0);
        tick();
        check_all("press_edge", 4'h1, 4'h1, 4'h0);
        tick();
        check_all("press_after", 4'h1, 4'h0, 4'h0);

        // 3: glitch on ch1 (3 high, 1 low, 3 high) is rejected
        seen_rise = '0;
        btn_raw = 4'h3;
        for (int i = 0; i < 7; i++) begin
            btn_raw = (i == 3) ? 4'h1 : 4'h3;
            tick();
            seen_rise |= db_rise;
        end
        check("glitch_rise", 32'(seen_rise), 32'h0);
        check("glitch_level", 32'(db_level), 32'h1);
        btn_raw = 4'h1;
        tick(LAT + 2);
        check_all("glitch_settle", 4'h1, 4'h0, 4'h0);

        // toggling every cycle never produces a pulse
        seen_rise = '0;
        for (int i = 0; i < 12; i++) begin
            btn_raw = (i % 2 == 0) ? 4'h3 : 4'h1;
            tick();
            seen_rise |= db_rise | db_fall;
        end
        btn_raw = 4'h1;
        check("toggle_pulses", 32'(seen_rise), 32'h0);
        tick(LAT + 2);
        check_all("toggle_settle", 4'h1, 4'h0, 4'h0);

        // 4: simultaneous press on ch2/ch3, then release ch2
        btn_raw = 4'hD;
        tick(LAT - 1);
        check_all("simul_pre", 4'h1, 4'h0, 4'h0);
        tick();
        check_all("simul_edge", 4'hD, 4'hC, 4'h0);
        tick();
        btn_raw = 4'h9;
        tick(LAT);
        check_all("rel_ch2", 4'h9, 4'h0, 4'h4);
        tick();
        check_all("rel_ch2_after", 4'h9, 4'h0, 4'h0);

        // 5: reset aborts a count in progress
        btn_raw = 4'h0;
        tick(LAT);
        check_all("to_idle", 4'h0, 4'h0, 4'h9);
        tick();
        btn_raw = 4'h1;
        tick(2);
        rst = 1'b1;
        tick();
        check_all("midrst_hold", 4'h0, 4'h0, 4'h0);
        rst = 1'b0;
        tick(LAT - 1);
        check_all("midrst_pre", 4'h0, 4'h0, 4'h0);
        tick();
        check_all("midrst_edge", 4'h1, 4'h1, 4'h0);
        tick();
        check_all("midrst_after", 4'h1, 4'h0, 4'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
